// File: rtl/fetch_queue.sv
// fetch_queue: RV32I fetch front end with pipelined imem requests and a PC/instruction queue
module fetch_queue #(
    parameter logic [31:0] RESET_PC        = 32'h0100_0000,
    parameter int          DEPTH           = 4,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       redirect,
    input  logic [31:0]                redirect_pc,
    output logic                       imem_req,
    output logic [31:0]                imem_addr,
    input  logic                       imem_gnt,
    input  logic                       imem_rvalid,
    input  logic [31:0]                imem_rdata,
    output logic                       dec_valid,
    output logic [31:0]                dec_instr,
    output logic [31:0]                dec_pc,
    input  logic                       dec_ready,
    output logic [$clog2(DEPTH):0]     fq_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    logic [31:0]   fetch_pc, resp_pc;
    logic [CW-1:0] count;
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [OW-1:0] outstanding, drop, out_n, drop_n;
    logic [OW:0]   out_sum, drop_sum;
    logic [31:0]   instr_q [DEPTH];
    logic [31:0]   pc_q [DEPTH];
    logic          issue, rsp, push, pop;
    always_comb begin
        imem_req  = !reset && !redirect && int'(outstanding) < MAX_OUTSTANDING &&
                    int'(count) + int'(outstanding) < DEPTH;
        imem_addr = fetch_pc;
        issue     = imem_req && imem_gnt;
        rsp       = imem_rvalid && outstanding != '0;
        dec_valid = count != '0;
        push      = rsp && drop == '0 && !redirect;
        pop       = dec_valid && dec_ready && !redirect;
        out_sum   = {1'b0, outstanding} + (OW+1)'(issue) - (OW+1)'(rsp);
        drop_sum  = {1'b0, drop} + {1'b0, outstanding} - (OW+1)'(rsp);
        out_n     = int'(out_sum) > MAX_OUTSTANDING ? OW'(MAX_OUTSTANDING) : out_sum[OW-1:0];
        drop_n    = int'(drop_sum) > MAX_OUTSTANDING ? OW'(MAX_OUTSTANDING) : drop_sum[OW-1:0];
        dec_instr = dec_valid ? instr_q[rd_ptr] : 32'h13;
        dec_pc    = dec_valid ? pc_q[rd_ptr] : 32'h0;
        fq_count  = count;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            outstanding <= '0;
            drop        <= '0;
        end else begin
            outstanding <= out_n;
            if (redirect) begin
                fetch_pc <= redirect_pc & ~32'h3;
                resp_pc  <= redirect_pc & ~32'h3;
                count    <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                drop     <= drop_n;
            end else begin
                if (issue) fetch_pc <= fetch_pc + 32'd4;
                if (push) resp_pc <= resp_pc + 32'd4;
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop) rd_ptr <= rd_ptr + 1'b1;
                if (rsp && drop != '0) drop <= drop - 1'b1;
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end
    always_ff @(posedge clock) begin
        if (push) begin
            instr_q[wr_ptr] <= imem_rdata;
            pc_q[wr_ptr]    <= resp_pc;
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed checks of fetch_queue against an in-order variable-latency imem model
module tb_fetch_queue;
    logic        clock = 1'b0;
    logic        reset, redirect, imem_req, imem_gnt, imem_rvalid, dec_valid, dec_ready;
    logic [31:0] redirect_pc, imem_addr, imem_rdata, dec_instr, dec_pc;
    logic [2:0]  fq_count;
    int          errors = 0;
    int          checks = 0;
    int          lat = 1;
    int          cyc = 0;
    logic [31:0] q_addr [$];
    int          q_due [$];

    fetch_queue dut (
        .clock(clock), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .dec_valid(dec_valid), .dec_instr(dec_instr), .dec_pc(dec_pc),
        .dec_ready(dec_ready), .fq_count(fq_count)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    // imem model: request issued in cycle N returns in cycle N+lat, in order
    always @(posedge clock) begin
        if (reset) begin
            q_addr.delete();
            q_due.delete();
            imem_rvalid <= 1'b0;
            imem_rdata  <= 32'h0;
        end else begin
            if (imem_req && imem_gnt) begin
                q_addr.push_back(imem_addr);
                q_due.push_back(cyc + lat - 1);
            end
            if (q_due.size() > 0 && q_due[0] == cyc) begin
                imem_rvalid <= 1'b1;
                imem_rdata  <= word(q_addr[0]);
                void'(q_addr.pop_front());
                void'(q_due.pop_front());
            end else begin
                imem_rvalid <= 1'b0;
                imem_rdata  <= 32'h0;
            end
        end
        cyc = cyc + 1;
    end

    always @(negedge clock) begin
        checks++;
        assert (fq_count <= 3'd4) else begin
            errors++;
            $error("FAIL overflow: observed=%0d expected<=4", fq_count);
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_req"}, 32'(imem_req), 32'd0);
        chk({tag, "_valid"}, 32'(dec_valid), 32'd0);
        chk({tag, "_instr"}, dec_instr, 32'h13);
        chk({tag, "_pc"}, dec_pc, 32'h0);
        chk({tag, "_count"}, 32'(fq_count), 32'd0);
    endtask

    initial begin
        reset = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; imem_gnt = 1'b1; dec_ready = 1'b0;
        step();
        step();
        chk_reset("rst");
        // zero-wait memory, streaming
        reset = 1'b0; dec_ready = 1'b1; #1;
        chk("c0_req", 32'(imem_req), 32'd1);
        chk("c0_addr", imem_addr, 32'h0100_0000);
        chk("c0_valid", 32'(dec_valid), 32'd0);
        chk("c0_instr", dec_instr, 32'h13);
        step();
        chk("c1_valid", 32'(dec_valid), 32'd0);
        chk("c1_addr", imem_addr, 32'h0100_0004);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("stream_valid", 32'(dec_valid), 32'd1);
            chk("stream_pc", dec_pc, 32'h0100_0000 + 32'(4 * i));
            chk("stream_instr", dec_instr, word(32'h0100_0000 + 32'(4 * i)));
        end
        // decode stall fills the queue, then drains in order
        dec_ready = 1'b0;
        repeat (10) step();
        chk("stall_count", 32'(fq_count), 32'd4);
        chk("stall_req", 32'(imem_req), 32'd0);
        chk("stall_head", dec_pc, 32'h0100_000C);
        dec_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("drain_valid", 32'(dec_valid), 32'd1);
            chk("drain_pc", dec_pc, 32'h0100_000C + 32'(4 * i));
            step();
        end
        chk("pre_redir_pc", dec_pc, 32'h0100_0020);
        chk("pre_redir_rvalid", 32'(imem_rvalid), 32'd1);
        // redirect coincident with a response and a pop
        redirect = 1'b1; redirect_pc = 32'h0200_0008; #1;
        chk("redir_req", 32'(imem_req), 32'd0);
        step();
        redirect = 1'b0; #1;
        chk("redir_count", 32'(fq_count), 32'd0);
        chk("redir_valid", 32'(dec_valid), 32'd0);
        chk("redir_req1", 32'(imem_req), 32'd1);
        chk("redir_addr", imem_addr, 32'h0200_0008);
        step();
        chk("redir_valid1", 32'(dec_valid), 32'd0);
        step();
        chk("redir_first_pc", dec_pc, 32'h0200_0008);
        chk("redir_first_instr", dec_instr, word(32'h0200_0008));
        // 2-cycle memory, redirect with two requests in flight
        reset = 1'b1;
        step();
        reset = 1'b0; lat = 2;
        repeat (5) step();
        chk("l2_count", 32'(fq_count), 32'd0);
        chk("l2_rvalid", 32'(imem_rvalid), 32'd1);
        redirect = 1'b1; redirect_pc = 32'h0100_0101;
        step();
        redirect = 1'b0; #1;
        chk("l2_addr", imem_addr, 32'h0100_0100);
        chk("l2_req", 32'(imem_req), 32'd1);
        chk("l2_drop6", 32'(dec_valid), 32'd0);
        step();
        chk("l2_drop7", 32'(dec_valid), 32'd0);
        step();
        chk("l2_drop8", 32'(dec_valid), 32'd0);
        step();
        chk("l2_first_valid", 32'(dec_valid), 32'd1);
        chk("l2_first_pc", dec_pc, 32'h0100_0100);
        chk("l2_first_instr", dec_instr, word(32'h0100_0100));
        step();
        chk("l2_second_pc", dec_pc, 32'h0100_0104);
        // reset mid-operation with two requests in flight
        reset = 1'b1;
        step();
        reset = 1'b0; lat = 3; dec_ready = 1'b0;
        repeat (6) step();
        chk("l3_count", 32'(fq_count), 32'd2);
        chk("l3_req", 32'(imem_req), 32'd0);
        reset = 1'b1;
        step();
        chk_reset("midrst");
        reset = 1'b0; lat = 1; dec_ready = 1'b1; #1;
        chk("restart_req", 32'(imem_req), 32'd1);
        chk("restart_addr", imem_addr, 32'h0100_0000);
        step();
        step();
        chk("restart_valid", 32'(dec_valid), 32'd1);
        chk("restart_pc", dec_pc, 32'h0100_0000);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
